stage_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the core pipeline stages: FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Drives the 3-bit stage select consumed by the decode/register-file stage.
- Handshakes with instruction and data memory.
- Issues the IR, register-file and PC write strobes.
- Counts retired instructions.
- Sits between the top-level core and the fetch/decode/execute datapath blocks.

---
 rtl/stage_sequencer.sv | 134 +++++++++++++
 tb/tb_stage_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with retired-instruction count.
// Optional memory-ack timeout fault: define PILLAR_STAGE_TIMEOUT_EN.
module stage_sequencer #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  input  logic             mem_op_i,
  input  logic             wb_op_i,
  input  logic             stall_i,
  input  logic             halt_i,
  output logic [2:0]       stage_o,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             ir_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             halted_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd7
  } stage_t;

  stage_t           state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;
  logic             timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    state_next = state_reg;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_HALT;
        end
      end
      S_DECODE:  if (!stall_i) state_next = S_EXECUTE;
      S_EXECUTE: if (!stall_i) state_next = mem_op_i ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i)       state_next = S_WRITEBACK;
        else if (timeout_hit) state_next = S_HALT;
      end
      S_WRITEBACK: begin
        if (!stall_i) begin
          rf_we_o    = wb_op_i;
          pc_we_o    = 1'b1;
          retire     = 1'b1;
          state_next = halt_i ? S_HALT : S_FETCH;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    // Reset abandons the instruction: nothing may leave the block this cycle.
    if (reset) begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      rf_we_o    = 1'b0;
      pc_we_o    = 1'b0;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) retired_reg <= retired_reg + 1'b1;
    end
  end

`ifdef PILLAR_STAGE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_reg;
  logic              err_reg;
  logic              waiting;

  assign waiting     = (state_reg == S_FETCH  && !imem_ack_i) ||
                       (state_reg == S_MEMORY && !dmem_ack_i);
  // The current wait cycle is the TIMEOUT_CYCLES-th one; an ack this cycle still wins.
  assign timeout_hit = (wait_reg == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (state_next != state_reg) wait_reg <= '0;
      else if (waiting)            wait_reg <= wait_reg + 1'b1;
      if (waiting && timeout_hit) err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign stage_o   = state_reg;
  assign retired_o = retired_reg;
  assign halted_o  = (state_reg == S_HALT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: ALU/load/stall/halt/reset sequences, counter wrap,
// and ack-timeout behaviour (checked for whichever build of PILLAR_STAGE_TIMEOUT_EN is active).
module tb_stage_sequencer;
  localparam int CNT_W = 3;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_ack_i = 1'b0, dmem_ack_i = 1'b0, mem_op_i = 1'b0, wb_op_i = 1'b0;
  logic stall_i = 1'b0, halt_i = 1'b0;
  logic [2:0]       stage_o;
  logic             imem_req_o, dmem_req_o, ir_we_o, rf_we_o, pc_we_o, halted_o, err_o;
  logic [CNT_W-1:0] retired_o;

  int n_cmp = 0;
  int n_bad = 0;

  stage_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .mem_op_i(mem_op_i), .wb_op_i(wb_op_i),
    .stall_i(stall_i), .halt_i(halt_i),
    .stage_o(stage_o), .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o),
    .ir_we_o(ir_we_o), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o),
    .retired_o(retired_o), .halted_o(halted_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; callers then set inputs and settle #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One ALU instruction from FETCH with an immediate ack; 4 cycles.
  task automatic run_alu(input logic wb, input logic [31:0] exp_ret);
    imem_ack_i = 1'b1; mem_op_i = 1'b0; wb_op_i = wb; #1;
    check("alu_fetch_stage", stage_o, 0);
    check("alu_ir_we", ir_we_o, 1);
    cyc(); imem_ack_i = 1'b0; #1;
    check("alu_decode_stage", stage_o, 1);
    cyc(); #1;
    check("alu_exec_stage", stage_o, 2);
    cyc(); #1;
    check("alu_wb_stage", stage_o, 4);
    check("alu_rf_we", rf_we_o, 32'(wb));
    check("alu_pc_we", pc_we_o, 1);
    cyc(); #1;
    check("alu_back_fetch", stage_o, 0);
    check("alu_retired", retired_o, exp_ret);
  endtask

  initial begin
    int ncyc;

    // Reset: acks present but strobes must stay low.
    imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
    cyc(); cyc(); #1;
    check("rst_stage", stage_o, 0);
    check("rst_retired", retired_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_err", err_o, 0);
    check("rst_imem_req", imem_req_o, 0);
    check("rst_ir_we", ir_we_o, 0);
    reset = 1'b0; dmem_ack_i = 1'b0;

    // 1: ALU instruction, ir_we in cycle 1, rf/pc in cycle 4.
    imem_ack_i = 1'b1; wb_op_i = 1'b1; #1;
    check("t1_fetch_req", imem_req_o, 1);
    check("t1_ir_we", ir_we_o, 1);
    cyc(); #1;  // imem_ack still high in DECODE: must be ignored
    check("t1_decode", stage_o, 1);
    check("t1_ack_ignored_ir_we", ir_we_o, 0);
    imem_ack_i = 1'b0;
    cyc(); #1;
    check("t1_execute", stage_o, 2);
    check("t1_no_pc_we_exec", pc_we_o, 0);
    cyc(); #1;
    check("t1_wb", stage_o, 4);
    check("t1_rf_we", rf_we_o, 1);
    check("t1_pc_we", pc_we_o, 1);
    check("t1_retired_before", retired_o, 0);
    cyc(); #1;
    check("t1_fetch_again", stage_o, 0);
    check("t1_retired_after", retired_o, 1);

    // 2: load, dmem ack delayed 3 cycles -> 4 cycles in MEMORY, 8 total.
    ncyc = 0;
    imem_ack_i = 1'b1; mem_op_i = 1'b1; wb_op_i = 1'b1; #1;
    cyc(); ncyc++; imem_ack_i = 1'b0; #1;
    cyc(); ncyc++; #1;
    check("t2_exec", stage_o, 2);
    cyc(); ncyc++;
    for (int i = 0; i < 4; i++) begin
      imem_ack_i = (i == 0);  // stray imem ack in MEMORY
      dmem_ack_i = (i == 3);
      #1;
      check("t2_mem_stage", stage_o, 3);
      check("t2_dmem_req", dmem_req_o, 1);
      check("t2_mem_no_ir_we", ir_we_o, 0);
      cyc(); ncyc++;
    end
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0; mem_op_i = 1'b0; #1;
    check("t2_wb", stage_o, 4);
    check("t2_dmem_req_off", dmem_req_o, 0);
    check("t2_pc_we", pc_we_o, 1);
    cyc(); ncyc++; #1;
    check("t2_cycles", 32'(ncyc), 8);
    check("t2_fetch", stage_o, 0);
    check("t2_retired", retired_o, 2);

    // 3+4: stalls in EXECUTE and WRITEBACK, then halt on the 3rd instruction.
    imem_ack_i = 1'b1; #1;
    cyc(); imem_ack_i = 1'b0; #1;
    cyc(); stall_i = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      check("t3_exec_hold", stage_o, 2);
      cyc(); #1;
    end
    check("t3_exec_still", stage_o, 2);
    stall_i = 1'b0;
    cyc(); stall_i = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      check("t3_wb_hold", stage_o, 4);
      check("t3_wb_hold_rf_we", rf_we_o, 0);
      check("t3_wb_hold_pc_we", pc_we_o, 0);
      check("t3_wb_hold_retired", retired_o, 2);
      cyc(); #1;
    end
    stall_i = 1'b0; halt_i = 1'b1; #1;
    check("t3_release_stage", stage_o, 4);
    check("t3_release_rf_we", rf_we_o, 1);
    check("t3_release_pc_we", pc_we_o, 1);
    cyc(); halt_i = 1'b0; #1;
    check("t4_halt_stage", stage_o, 7);
    check("t4_halted", halted_o, 1);
    check("t4_retired", retired_o, 3);
    check("t4_imem_req", imem_req_o, 0);
    imem_ack_i = 1'b1; #1;
    check("t4_ack_ir_we", ir_we_o, 0);
    cyc(); imem_ack_i = 1'b0; #1;
    check("t4_still_halt", stage_o, 7);
    check("t4_pc_we_halt", pc_we_o, 0);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("t4_rst_stage", stage_o, 0);
    check("t4_rst_retired", retired_o, 0);
    check("t4_rst_halted", halted_o, 0);

    // Counter wrap with wb_op=0 instructions (3-bit counter).
    for (int k = 0; k < 8; k++) run_alu(1'b0, 32'((k + 1) % 8));

    // 5: reset while in MEMORY with request high.
    imem_ack_i = 1'b1; mem_op_i = 1'b1; #1;
    cyc(); imem_ack_i = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    check("t5_mem_stage", stage_o, 3);
    check("t5_dmem_req", dmem_req_o, 1);
    reset = 1'b1; dmem_ack_i = 1'b1; #1;
    check("t5_rst_dmem_req", dmem_req_o, 0);
    check("t5_rst_rf_we", rf_we_o, 0);
    check("t5_rst_pc_we", pc_we_o, 0);
    cyc(); reset = 1'b0; dmem_ack_i = 1'b0; mem_op_i = 1'b0; #1;
    check("t5_stage", stage_o, 0);
    check("t5_dmem_req_after", dmem_req_o, 0);
    check("t5_pc_we_after", pc_we_o, 0);
    check("t5_fetch_req", imem_req_o, 1);

    // 6: withheld instruction ack.
`ifdef PILLAR_STAGE_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      check("t6_wait_fetch", stage_o, 0);
      check("t6_wait_err", err_o, 0);
      cyc(); #1;
    end
    check("t6_timeout_stage", stage_o, 7);
    check("t6_timeout_err", err_o, 1);
    check("t6_timeout_halted", halted_o, 1);
    cyc(); #1;
    check("t6_err_sticky", err_o, 1);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("t6_rst_err", err_o, 0);
    for (int i = 0; i < TMO - 1; i++) begin
      cyc(); #1;
    end
    imem_ack_i = 1'b1; #1;
    check("t6_limit_ack_ir_we", ir_we_o, 1);
    cyc(); imem_ack_i = 1'b0; #1;
    check("t6_limit_ack_decode", stage_o, 1);
    check("t6_limit_ack_err", err_o, 0);
`else
    for (int i = 0; i < 3 * TMO; i++) begin
      cyc();
    end
    #1;
    check("t6_nomacro_stage", stage_o, 0);
    check("t6_nomacro_req", imem_req_o, 1);
    check("t6_nomacro_err", err_o, 0);
    check("t6_nomacro_halted", halted_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
